// File: rtl/nap_pkg.sv
// Shared nap-timer definitions used by the selector, countdown and display stages.
// Holds the state encoding, the duration limit and the keypad increment arithmetic.
package nap_pkg;

  typedef enum logic [1:0] {
    NAP_IDLE  = 2'd0,
    NAP_RUN   = 2'd1,
    NAP_ALARM = 2'd2
  } nap_state_t;

  localparam int NAP_MAX_SEC = 5999;
  localparam int NAP_BCD_W   = 4;
  localparam int NAP_TOTAL_W = 13;
  // One bit of headroom so a full-scale add on top of 99:59 cannot wrap before saturation.
  localparam int NAP_SUM_W   = 14;

  function automatic logic [NAP_SUM_W-1:0] nap_increment(input logic [3:0] one_sec,
                                                         input logic [3:0] ten_sec,
                                                         input logic [3:0] one_min);
    return NAP_SUM_W'(one_sec)
         + NAP_SUM_W'(ten_sec) * NAP_SUM_W'(10)
         + NAP_SUM_W'(one_min) * NAP_SUM_W'(60);
  endfunction

endpackage

// File: rtl/nap_countdown_sec_tick_gen.sv
// Free-running 1 s prescaler: one-cycle tick when the count reaches CLK_HZ-1.
// clear holds the count at zero; no backpressure.
module sec_tick_gen #(
  parameter int CLK_HZ = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/nap_countdown.sv
// Nap timer: accumulates keypad increments while idle, counts down once per second, raises alarm at zero.
// Digits follow an add one cycle after the sample; first decrement CLK_HZ cycles after start; no backpressure.
module nap_countdown
  import nap_pkg::*;
#(
  parameter int CLK_HZ  = 1000,
  parameter int MAX_SEC = NAP_MAX_SEC
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [3:0]           one_sec,
  input  logic [3:0]           ten_sec,
  input  logic [3:0]           one_min,
  input  logic                 completeSetting,
  input  logic                 stop,
  output logic                 setup_en,
  output logic                 running,
  output logic                 alarm,
  output logic [NAP_BCD_W-1:0] min_tens,
  output logic [NAP_BCD_W-1:0] min_ones,
  output logic [NAP_BCD_W-1:0] sec_tens,
  output logic [NAP_BCD_W-1:0] sec_ones
);

  localparam logic [NAP_SUM_W-1:0] MAX_SUM = NAP_SUM_W'(MAX_SEC);

  nap_state_t             state;
  logic [NAP_TOTAL_W-1:0] total;
  logic [NAP_SUM_W-1:0]   add_sum;
  logic [NAP_TOTAL_W-1:0] total_sat;
  logic                   tick;
  logic                   tick_clear;
  logic [6:0]             minutes;
  logic [5:0]             seconds;

  always_comb begin
    add_sum   = NAP_SUM_W'(total) + nap_increment(one_sec, ten_sec, one_min);
    total_sat = (add_sum > MAX_SUM) ? NAP_TOTAL_W'(MAX_SUM) : NAP_TOTAL_W'(add_sum);
  end

  // The prescaler only runs in RUN, so every countdown starts from a fresh second.
  assign tick_clear = (state != NAP_RUN) || stop;

  sec_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_sec_tick_gen (
    .clock(clock),
    .reset(reset),
    .clear(tick_clear),
    .tick (tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= NAP_IDLE;
      total <= '0;
    end else begin
      case (state)
        NAP_IDLE: begin
          if (stop) begin
            total <= '0;
          end else begin
            total <= total_sat;
            if (completeSetting && (total_sat != '0)) begin
              state <= NAP_RUN;
            end
          end
        end
        NAP_RUN: begin
          if (stop) begin
            state <= NAP_IDLE;
            total <= '0;
          end else if (tick) begin
            if (total <= NAP_TOTAL_W'(1)) begin
              total <= '0;
              state <= NAP_ALARM;
            end else begin
              total <= total - NAP_TOTAL_W'(1);
            end
          end
        end
        NAP_ALARM: begin
          total <= '0;
          if (stop) begin
            state <= NAP_IDLE;
          end
        end
        default: begin
          state <= NAP_IDLE;
          total <= '0;
        end
      endcase
    end
  end

  assign setup_en = (state == NAP_IDLE);
  assign running  = (state == NAP_RUN);
  assign alarm    = (state == NAP_ALARM);

  always_comb begin
    minutes  = 7'(total / NAP_TOTAL_W'(60));
    seconds  = 6'(total % NAP_TOTAL_W'(60));
    min_tens = NAP_BCD_W'(minutes / 7'd10);
    min_ones = NAP_BCD_W'(minutes % 7'd10);
    sec_tens = NAP_BCD_W'(seconds / 6'd10);
    sec_ones = NAP_BCD_W'(seconds % 6'd10);
  end

endmodule
